// File: rtl/crono_pkg.sv
// Shared definitions for the chronometer setpoint/alarm block: FSM state
// encoding, edit field codes, BCD field limits and the BCD step helper used
// by every setpoint field.
package crono_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2
  } crono_state_e;

  localparam logic [1:0] CAMPO_SEG  = 2'd0;
  localparam logic [1:0] CAMPO_MIN  = 2'd1;
  localparam logic [1:0] CAMPO_HORA = 2'd2;
  localparam logic [1:0] CAMPO_NONE = 2'd3;

  localparam logic [7:0] MAX_SEG  = 8'h59;
  localparam logic [7:0] MAX_MIN  = 8'h59;
  localparam logic [7:0] MAX_HORA = 8'h23;

  // One BCD step up or down inside 00..lim, wrapping at both ends.
  // The units digit carries/borrows into the tens digit.
  function automatic logic [7:0] bcd_step(input logic [7:0] v,
                                          input logic [7:0] lim,
                                          input logic       up);
    logic [7:0] r;
    r = v;
    if (up) begin
      if (v == lim)              r = 8'h00;
      else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
      else                       r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v == 8'h00)            r = lim;
      else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
      else                       r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_campo_updn.sv
// One BCD setpoint field (seconds, minutes or hours) with up/down stepping
// and wrap at 00 and at the field maximum. A simultaneous inc and dec is
// treated as no request.
module bcd_campo_updn
  import crono_pkg::*;
(
  input  logic       reloj,
  input  logic       resetM,
  input  logic       en,
  input  logic       inc,
  input  logic       dec,
  input  logic [7:0] max,
  output logic [7:0] q
);

  // Field register: steps once per accepted inc/dec pulse.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      q <= 8'h00;
    end else if (en && (inc ^ dec)) begin
      q <= bcd_step(q, max, inc);
    end
  end

endmodule

// File: rtl/crono_setpoint_alarma.sv
// Chronometer setpoint and alarm. Holds the BCD hh:mm:ss setpoint driven on
// alarma, captures the timer readback on each falling edge of READ, and rings
// (crono_fin high, 4 Hz buzzer) when a captured value equals the setpoint
// while the chrono runs. Ringing ends on ack.
// Optional macro CRONO_RING_TIMEOUT_EN: ringing also ends on its own after
// RING_SEC seconds.
// Handshake note: there is no valid/ready pair here; inc, dec and ack are
// single-cycle pulses sampled on the rising edge of reloj, READ is a level
// whose falling edge marks the readback as valid for capture.
module crono_setpoint_alarma
  import crono_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int RING_SEC = 10
) (
  input  logic         reloj,
  input  logic         resetM,
  input  logic         edit_en,
  input  logic [1:0]   campo_sel,
  input  logic         inc,
  input  logic         dec,
  input  logic         act_crono,
  input  logic         READ,
  input  logic [7:0]   IN_segcr,
  input  logic [7:0]   IN_mincr,
  input  logic [7:0]   IN_horacr,
  input  logic         ack,
  output logic [23:0]  alarma,
  output logic         crono_fin,
  output logic         buzzer,
  output crono_state_e state_dbg
);

  localparam int DIV4 = (CLK_HZ / 4 > 1) ? CLK_HZ / 4 : 1;
  localparam int W4   = (DIV4 > 1) ? $clog2(DIV4) : 1;

  crono_state_e state, next_state;

  logic [7:0]  sp_s, sp_m, sp_h;
  logic [23:0] setpoint;
  logic        edit_ok;
  logic        en_s, en_m, en_h;

  logic        read_q;
  logic        read_fall;
  logic [23:0] snapshot;
  logic        cmp_v;

  logic [W4-1:0] div4_cnt;
  logic          tick_4hz;
  logic          ring_timeout;

  // ---------------------------------------------------------------------
  // Setpoint fields: editable only while idle with edit mode on.
  // ---------------------------------------------------------------------
  assign edit_ok = (state == IDLE) && edit_en;
  assign en_s    = edit_ok && (campo_sel == CAMPO_SEG);
  assign en_m    = edit_ok && (campo_sel == CAMPO_MIN);
  assign en_h    = edit_ok && (campo_sel == CAMPO_HORA);

  bcd_campo_updn u_seg (
    .reloj  (reloj),
    .resetM (resetM),
    .en     (en_s),
    .inc    (inc),
    .dec    (dec),
    .max    (MAX_SEG),
    .q      (sp_s)
  );

  bcd_campo_updn u_min (
    .reloj  (reloj),
    .resetM (resetM),
    .en     (en_m),
    .inc    (inc),
    .dec    (dec),
    .max    (MAX_MIN),
    .q      (sp_m)
  );

  bcd_campo_updn u_hora (
    .reloj  (reloj),
    .resetM (resetM),
    .en     (en_h),
    .inc    (inc),
    .dec    (dec),
    .max    (MAX_HORA),
    .q      (sp_h)
  );

  assign setpoint = {sp_h, sp_m, sp_s};
  assign alarma   = setpoint;

  // ---------------------------------------------------------------------
  // Readback capture on the falling edge of READ.
  // ---------------------------------------------------------------------
  assign read_fall = read_q && !READ;

  // Snapshot the timer readback and flag it for one comparison cycle.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      read_q   <= 1'b0;
      snapshot <= 24'h0;
      cmp_v    <= 1'b0;
    end else begin
      read_q <= READ;
      cmp_v  <= read_fall;
      if (read_fall) begin
        snapshot <= {IN_horacr, IN_mincr, IN_segcr};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Optional ring timeout: 1 Hz divider plus seconds counter, both
  // restarting whenever the block is not ringing.
  // ---------------------------------------------------------------------
`ifdef CRONO_RING_TIMEOUT_EN
  localparam int W1 = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int WS = $clog2(RING_SEC + 1);

  logic [W1-1:0] div1_cnt;
  logic [WS-1:0] sec_cnt;
  logic          tick_1hz;

  assign tick_1hz     = (div1_cnt == W1'(CLK_HZ - 1));
  assign ring_timeout = tick_1hz && (sec_cnt == WS'(RING_SEC - 1));

  // Count ringing seconds from RINGING entry.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      div1_cnt <= '0;
      sec_cnt  <= '0;
    end else if (state != RINGING) begin
      div1_cnt <= '0;
      sec_cnt  <= '0;
    end else if (tick_1hz) begin
      div1_cnt <= '0;
      sec_cnt  <= sec_cnt + WS'(1);
    end else begin
      div1_cnt <= div1_cnt + W1'(1);
    end
  end
`else
  localparam int ring_sec_unused = RING_SEC;
  assign ring_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Alarm FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; dropping act_crono wins over a same-cycle match.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (act_crono && !edit_en && (setpoint != 24'h0)) begin
          next_state = ARMED;
        end
      end
      ARMED: begin
        if (!act_crono) begin
          next_state = IDLE;
        end else if (cmp_v && (snapshot == setpoint)) begin
          next_state = RINGING;
        end
      end
      RINGING: begin
        if (ack || ring_timeout) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign crono_fin = (state == RINGING);
  assign state_dbg = state;

  // ---------------------------------------------------------------------
  // Buzzer: 4 Hz toggle while ringing, forced low on the exit edge.
  // ---------------------------------------------------------------------
  assign tick_4hz = (div4_cnt == W4'(DIV4 - 1));

  // 4 Hz divider and buzzer flop, held clear outside RINGING.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      div4_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (next_state != RINGING) begin
      div4_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (state == RINGING) begin
      if (tick_4hz) begin
        div4_cnt <= '0;
        buzzer   <= !buzzer;
      end else begin
        div4_cnt <= div4_cnt + W4'(1);
      end
    end
  end

endmodule
